div_clk_monitor: RTL and testbench

//   Downstream stage of the divide-by-2/by-4 clock dividers. Samples a divided-clock output (div_in) as

---
 rtl/div_clk_monitor.sv | 130 +++++++++++++
 tb/tb_div_clk_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_clk_monitor.sv
// Monitors a divided clock sampled as data in the clk domain: edge count, rise-to-rise period,
// period-mismatch and stall flags. Define DIV_MON_SYNC_EN to add a 2-flop input synchronizer.
module div_clk_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             div_in,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             err,
    output logic             stall,
    output logic [15:0]      edge_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXP_PERIOD);

    state_t           state;
    logic [CNT_W-1:0] gap;
    logic             div_s;
    logic             div_q;
    logic             rise;

`ifdef DIV_MON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], div_in};
        end
    end

    assign div_s = sync_q[1];
`else
    // Only safe when div_in is produced by logic clocked from clk.
    assign div_s = div_in;
`endif

    assign rise      = div_s & ~div_q;
    assign state_dbg = state;

    // period_vld is a single-cycle strobe; period holds its value between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gap        <= '0;
            div_q      <= 1'b0;
            rise_pulse <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
            err        <= 1'b0;
            stall      <= 1'b0;
            edge_cnt   <= '0;
        end else begin
            div_q      <= div_s;
            rise_pulse <= rise & en;
            period_vld <= 1'b0;

            if (!en) begin
                state <= IDLE;
                gap   <= '0;
                stall <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        gap   <= '0;
                        state <= ARM;
                    end
                    ARM: begin
                        // The first rise here is only a reference; no period is measured.
                        if (rise) begin
                            state    <= RUN;
                            gap      <= CNT_W'(1);
                            stall    <= 1'b0;
                            edge_cnt <= edge_cnt + 16'd1;
                        end else if (gap == TIMEOUT_C) begin
                            stall <= 1'b1;
                        end else begin
                            gap <= gap + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        if (rise) begin
                            period     <= gap;
                            period_vld <= 1'b1;
                            gap        <= CNT_W'(1);
                            edge_cnt   <= edge_cnt + 16'd1;
                            if (gap != EXP_C) begin
                                err <= 1'b1;
                            end
                        end else if (gap == TIMEOUT_C) begin
                            stall <= 1'b1;
                            state <= ARM;
                            gap   <= '0;
                        end else begin
                            gap <= gap + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        gap   <= '0;
                    end
                endcase
            end

            // clr wins over any flag or counter update made above in the same cycle.
            if (clr) begin
                err      <= 1'b0;
                stall    <= 1'b0;
                edge_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench for div_clk_monitor: timestamp-based reference model, per-cycle expectations.
// Honours DIV_MON_SYNC_EN by delaying the model's view of div_in by two cycles.
module tb_div_clk_monitor;

    localparam int CNT_W      = 8;
    localparam int EXP_PERIOD = 4;
    localparam int TIMEOUT    = 64;
`ifdef DIV_MON_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clr;
    logic             div_in;
    logic             rise_pulse;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             err;
    logic             stall;
    logic [15:0]      edge_cnt;
    logic [1:0]       state_dbg;

    div_clk_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP_PERIOD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .div_in(div_in),
        .rise_pulse(rise_pulse), .period(period), .period_vld(period_vld),
        .err(err), .stall(stall), .edge_cnt(edge_cnt), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;
    bit done     = 1'b0;

    // Per-cycle expectation: {rise_pulse, stall, err, edge_cnt}; per-pulse: {period_vld, period}.
    logic [18:0]    lvl_q[$];
    logic [CNT_W:0] exp_q[$];

    // ---------------- reference model ----------------
    int               mcyc = 0;
    logic [3:0]       dh;
    bit               m_en_prev;
    bit               m_have_ref;
    int               m_ref_t;
    int               m_wait_t;
    bit               m_stall;
    bit               m_err;
    logic [15:0]      m_cnt;
    logic [CNT_W-1:0] m_period;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predicts the outputs visible after the clock edge that follows the current inputs.
    task automatic model_step();
        bit d, dp, rise, counted, vld;
        mcyc++;
        vld = 1'b0;
        if (rst) begin
            dh = '0; m_en_prev = 0; m_have_ref = 0; m_stall = 0; m_err = 0;
            m_cnt = '0; m_period = '0;
            lvl_q.push_back(19'd0);
            return;
        end
        dh      = {dh[2:0], div_in};
        d       = dh[SYNC_LAT];
        dp      = dh[SYNC_LAT+1];
        rise    = d & ~dp;
        counted = rise && en && m_en_prev;
        if (!en) begin
            m_have_ref = 0;
            m_stall    = 0;
        end else if (!m_en_prev) begin
            m_have_ref = 0;
            m_wait_t   = mcyc + 1;
        end else if (counted) begin
            if (m_have_ref) begin
                vld      = 1'b1;
                m_period = CNT_W'(mcyc - m_ref_t);
                if (mcyc - m_ref_t != EXP_PERIOD) m_err = 1;
            end
            m_cnt      = m_cnt + 16'd1;
            m_stall    = 0;
            m_have_ref = 1;
            m_ref_t    = mcyc;
        end else if (m_have_ref) begin
            if (mcyc - m_ref_t == TIMEOUT) begin
                m_stall    = 1;
                m_have_ref = 0;
                m_wait_t   = mcyc + 1;
            end
        end else if (mcyc - m_wait_t >= TIMEOUT) begin
            m_stall = 1;
        end
        if (clr) begin
            m_err = 0; m_stall = 0; m_cnt = '0;
        end
        m_en_prev = en;
        if (rise && en) exp_q.push_back({vld, m_period});
        lvl_q.push_back({rise && en, m_stall, m_err, m_cnt});
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic e, input logic c, input logic d);
        @(negedge clk);
        rst = r; en = e; clr = c; div_in = d;
        model_step();
        started = 1'b1;
    endtask

    task automatic wave(input int p, input int hi, input int reps);
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < p; k++) step(1'b0, 1'b1, 1'b0, k < hi);
    endtask

    task automatic lows(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) begin
        logic [18:0]    lv;
        logic [CNT_W:0] ev;
        #1;
        if (started && !done) begin
            if (lvl_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL lvl_q: no expectation for cycle at %0t", $time);
            end else begin
                lv = lvl_q.pop_front();
                check("rise_pulse", 32'(rise_pulse), 32'(lv[18]));
                check("stall", 32'(stall), 32'(lv[17]));
                check("err", 32'(err), 32'(lv[16]));
                check("edge_cnt", 32'(edge_cnt), 32'(lv[15:0]));
                if (lv[18]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL exp_q: pulse expectation missing at %0t", $time);
                    end else begin
                        ev = exp_q.pop_front();
                        check("period_vld", 32'(period_vld), 32'(ev[CNT_W]));
                        if (ev[CNT_W]) check("period", 32'(period), 32'(ev[CNT_W-1:0]));
                    end
                end else begin
                    check("period_vld_idle", 32'(period_vld), 32'd0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int off_left;
        logic e;
        rst = 1'b1; en = 1'b0; clr = 1'b0; div_in = 1'b0;

        // reset with div_in toggling
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, i[0]);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("state_after_reset", 32'(state_dbg), 32'd0);

        // nominal divide-by-4
        lows(2);
        wave(4, 2, 10);
        lows(4);
        check("cnt_after_10", 32'(edge_cnt), 32'd10);
        check("period_nominal", 32'(period), 32'd4);
        check("err_nominal", 32'(err), 32'd0);

        // wrong ratio, sticky err, clr
        wave(6, 3, 3);
        lows(4);
        check("err_set", 32'(err), 32'd1);
        check("period_6", 32'(period), 32'd6);
        wave(4, 2, 5);
        lows(4);
        check("err_sticky", 32'(err), 32'd1);
        check("period_back_4", 32'(period), 32'd4);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("err_clr", 32'(err), 32'd0);
        check("cnt_clr", 32'(edge_cnt), 32'd0);

        // stall and recovery
        wave(4, 2, 3);
        lows(70);
        check("stall_set", 32'(stall), 32'd1);
        wave(4, 2, 3);
        lows(4);
        check("stall_recovered", 32'(stall), 32'd0);
        check("period_after_stall", 32'(period), 32'd4);

        // enable dropped mid-run
        for (int i = 0; i < 28; i++) step(1'b0, !(i >= 6 && i < 16), 1'b0, (i % 4) < 2);

        // reset mid-operation
        wave(4, 2, 2);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_cnt", 32'(edge_cnt), 32'd0);
        wave(4, 2, 3);

        // randomized segments
        off_left = 0;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                lows($urandom_range(60, 75));
            end else begin
                int p, hi, reps;
                p    = $urandom_range(2, 8);
                hi   = $urandom_range(1, p - 1);
                reps = $urandom_range(1, 6);
                for (int r = 0; r < reps; r++) begin
                    for (int k = 0; k < p; k++) begin
                        if (off_left > 0) begin
                            e = 1'b0; off_left--;
                        end else if ($urandom_range(0, 99) < 2) begin
                            e = 1'b0; off_left = $urandom_range(1, 12);
                        end else begin
                            e = 1'b1;
                        end
                        step(1'b0, e, $urandom_range(0, 99) == 0, k < hi);
                    end
                end
            end
        end
        lows(4);

        @(posedge clk);
        #2;
        done = 1'b1;
        check("lvl_q_drained", 32'(lvl_q.size()), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
